// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared constants, state encoding and coding helpers for the negation-coded serial link
// neg_encode is self-inverse, so the receiver reuses it as its decoder.
package serial_link_pkg;

  localparam int DATA_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } link_state_t;

  // Works on a 32-bit carrier; callers truncate to their own symbol width.
  function automatic logic [31:0] neg_encode(input logic [31:0] word);
    return ~word + 32'd1;
  endfunction

  // Callers zero-extend the word, so the unused upper bits add nothing to the parity.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_neg_tx_if.sv
// rtl/serial_neg_tx_if.sv - symbol input handshake between a producer and serial_neg_tx
interface serial_neg_tx_if #(
  parameter int DATA_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/serial_neg_tx.sv
// rtl/serial_neg_tx.sv - negation-coded MSB-first serializer with optional idle gap between frames
// Optional even-parity bit after the LSB when SERIAL_NEG_TX_PARITY_EN is defined.
module serial_neg_tx
  import serial_link_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int GAP_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  serial_neg_tx_if.slave  s_if,
  output logic            ser_out,
  output logic            busy,
  output logic            done
);

`ifdef SERIAL_NEG_TX_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_GAP   = GAP;

  logic [1:0]         r_state;
  logic [FRAME_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_gap;
  logic               r_ser;

  logic [DATA_W-1:0]  w_enc;
  logic [FRAME_W-1:0] w_frame;
  logic               w_last;
  logic               w_ready;
  logic               w_accept;

  assign w_enc = DATA_W'(neg_encode(32'(s_if.in_data)));

`ifdef SERIAL_NEG_TX_PARITY_EN
  assign w_frame = {w_enc, even_parity(32'(w_enc))};
`else
  assign w_frame = w_enc;
`endif

  // The final-bit cycle doubles as an accept window when no gap follows.
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == '0);
  assign w_ready  = (r_state == S_IDLE) || (w_last && (GAP_CYCLES == 0));
  assign w_accept = s_if.in_valid && w_ready;

  assign s_if.in_ready = w_ready;
  assign ser_out       = r_ser;
  assign busy          = (r_state != S_IDLE);
  assign done          = w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_ser   <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_SHIFT;
      r_shift <= w_frame;
      r_ser   <= w_frame[FRAME_W-1];
      r_cnt   <= CNT_W'(FRAME_W - 1);
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_shift <= r_shift << 1;
            r_ser   <= r_shift[FRAME_W-2];
            r_cnt   <= r_cnt - 1'b1;
          end else begin
            r_shift <= '0;
            r_ser   <= 1'b0;
            if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
              r_gap   <= 4'(GAP_CYCLES - 1);
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          r_ser <= 1'b0;
          if (r_gap == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        S_IDLE: begin
          r_ser <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ser   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_neg_tx.sv
// tb/tb_serial_neg_tx.sv - directed self-checking bench for serial_neg_tx (gap 0 and gap 2 instances)
module tb_serial_neg_tx;

`ifdef SERIAL_NEG_TX_PARITY_EN
  localparam int FRAME = 4;
`else
  localparam int FRAME = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ser0, busy0, done0;
  logic ser2, busy2, done2;
  int   n_chk = 0;
  int   n_fail = 0;

  // Hand-computed negation table for 3-bit symbols.
  logic [2:0] enc_tab [8] = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

  serial_neg_tx_if #(.DATA_W(3)) if0 ();
  serial_neg_tx_if #(.DATA_W(3)) if2 ();

  serial_neg_tx #(.DATA_W(3), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .s_if(if0.slave),
    .ser_out(ser0), .busy(busy0), .done(done0)
  );

  serial_neg_tx #(.DATA_W(3), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .s_if(if2.slave),
    .ser_out(ser2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_frame(input int sym);
    logic [2:0] e;
    e = enc_tab[sym];
`ifdef SERIAL_NEG_TX_PARITY_EN
    return {e, ^e};
`else
    return {1'b0, e};
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.in_valid = 1'b0; if0.in_data = 3'd0;
    if2.in_valid = 1'b0; if2.in_data = 3'd0;
    cyc(); cyc(); cyc();
    n_chk++;
    if ({ser0, busy0, done0, if0.in_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_dut0 got ser/busy/done/rdy=%b exp=0001", {ser0, busy0, done0, if0.in_ready});
    end
    rst = 1'b0;
    cyc();
    n_chk++;
    if ({ser2, busy2, done2, if2.in_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_dut2 got ser/busy/done/rdy=%b exp=0001", {ser2, busy2, done2, if2.in_ready});
    end
  endtask

  task automatic test_single(input int sym);
    logic [3:0] f;
    f = exp_frame(sym);
    if0.in_valid = 1'b1;
    if0.in_data  = 3'(sym);
    n_chk++;
    if (if0.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready sym=%0d got=%b exp=1", sym, if0.in_ready);
    end
    cyc();
    if0.in_valid = 1'b0;
    if0.in_data  = ~3'(sym);
    for (int k = 0; k < FRAME; k++) begin
      n_chk++;
      if (ser0 !== f[FRAME-1-k] || done0 !== (k == FRAME-1) || busy0 !== 1'b1) begin
        n_fail++;
        $display("FAIL single_bit sym=%0d bit=%0d got ser/done/busy=%b%b%b exp=%b%b1",
                 sym, k, ser0, done0, busy0, f[FRAME-1-k], (k == FRAME-1));
      end
      cyc();
    end
    n_chk++;
    if ({ser0, busy0, done0, if0.in_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_after sym=%0d got ser/busy/done/rdy=%b exp=0001", sym, {ser0, busy0, done0, if0.in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] f1, f2;
    f1 = exp_frame(3);
    f2 = exp_frame(6);
    if0.in_valid = 1'b1;
    if0.in_data  = 3'd3;
    cyc();
    if0.in_data = 3'd6;
    for (int k = 0; k < FRAME; k++) begin
      n_chk++;
      if (ser0 !== f1[FRAME-1-k] || if0.in_ready !== (k == FRAME-1)) begin
        n_fail++;
        $display("FAIL b2b_first bit=%0d got ser/rdy=%b%b exp=%b%b",
                 k, ser0, if0.in_ready, f1[FRAME-1-k], (k == FRAME-1));
      end
      cyc();
    end
    if0.in_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      n_chk++;
      if (ser0 !== f2[FRAME-1-k] || done0 !== (k == FRAME-1) || busy0 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_second bit=%0d got ser/done/busy=%b%b%b exp=%b%b1",
                 k, ser0, done0, busy0, f2[FRAME-1-k], (k == FRAME-1));
      end
      cyc();
    end
    n_chk++;
    if ({ser0, busy0, if0.in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_after got ser/busy/rdy=%b exp=001", {ser0, busy0, if0.in_ready});
    end
  endtask

  task automatic test_gap();
    logic [3:0] f;
    f = exp_frame(4);
    if2.in_valid = 1'b1;
    if2.in_data  = 3'd4;
    cyc();
    if2.in_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      n_chk++;
      if (ser2 !== f[FRAME-1-k] || done2 !== (k == FRAME-1) || if2.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_frame bit=%0d got ser/done/rdy=%b%b%b exp=%b%b0",
                 k, ser2, done2, if2.in_ready, f[FRAME-1-k], (k == FRAME-1));
      end
      cyc();
    end
    for (int g = 0; g < 2; g++) begin
      n_chk++;
      if ({ser2, busy2, done2, if2.in_ready} !== 4'b0100) begin
        n_fail++;
        $display("FAIL gap_idle cycle=%0d got ser/busy/done/rdy=%b exp=0100", g, {ser2, busy2, done2, if2.in_ready});
      end
      cyc();
    end
    n_chk++;
    if ({ser2, busy2, if2.in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL gap_after got ser/busy/rdy=%b exp=001", {ser2, busy2, if2.in_ready});
    end
  endtask

  task automatic test_reset_abort();
    if0.in_valid = 1'b1;
    if0.in_data  = 3'd2;
    cyc();
    if0.in_valid = 1'b0;
    n_chk++;
    if (ser0 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_bit1 got=%b exp=1", ser0);
    end
    cyc();
    n_chk++;
    if (ser0 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_bit2 got=%b exp=1", ser0);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({ser0, busy0, done0, if0.in_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL abort_async got ser/busy/done/rdy=%b exp=0001", {ser0, busy0, done0, if0.in_ready});
    end
    cyc(); cyc();
    rst = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      n_chk++;
      if (done0 !== 1'b0 || ser0 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet cycle=%0d got done/ser=%b%b exp=00", k, done0, ser0);
      end
      cyc();
    end
    test_single(5);
  endtask

  task automatic test_loopback();
    logic [3:0] rx;
    logic [2:0] w, dec;
    for (int s = 0; s < 8; s++) begin
      if0.in_valid = 1'b1;
      if0.in_data  = 3'(s);
      cyc();
      if0.in_valid = 1'b0;
      rx = '0;
      for (int k = 0; k < FRAME; k++) begin
        rx = {rx[2:0], ser0};
        cyc();
      end
`ifdef SERIAL_NEG_TX_PARITY_EN
      w = rx[3:1];
      n_chk++;
      if (rx[0] !== ^w) begin
        n_fail++;
        $display("FAIL loop_parity sym=%0d got=%b exp=%b", s, rx[0], ^w);
      end
`else
      w = rx[2:0];
`endif
      dec = 3'd0 - w;
      n_chk++;
      if (dec !== 3'(s)) begin
        n_fail++;
        $display("FAIL loop_decode sym=%0d got=%0d exp=%0d", s, dec, s);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single(1);
    test_single(2);
    test_back_to_back();
    test_gap();
    test_reset_abort();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_neg_tx.md
Name: serial_neg_tx

Overview:
Serializer and transmitter for the team's 3-bit negation-coded serial link. Accepts parallel symbols over a valid/ready handshake and encodes each as its two's-complement negation (mod 2^DATA_W). Shifts the encoded word out MSB-first, one bit per clock. Sits upstream of the link's shift-register receiver. Negation is self-inverse, so the receiver's decode map recovers the original symbol.

Parameters:
DATA_W, 3, symbol width in bits; frame length is DATA_W bits (DATA_W+1 with parity).
GAP_CYCLES, 0, idle cycles (ser_out=0) forced after each frame; range 0..15.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  symbol available on in_data.
in_ready  output  1  block can accept a symbol this cycle.
in_data  input  DATA_W  raw symbol.
ser_out  output  1  serial bit stream, registered.
busy  output  1  high while a frame or gap is in progress.
done  output  1  one-cycle pulse coincident with the last bit of a frame on ser_out.

Behaviour:
- Reset (async, rst=1): state=IDLE, shift reg=0, bit count=0, gap count=0, ser_out=0, busy=0, done=0. in_ready=1 (IDLE).
- Encoding: enc = (~in_data + 1) truncated to DATA_W bits. For DATA_W=3: 0→0, 1→7, 2→6, 3→5, 4→4, 5→3, 6→2, 7→1.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1, ser_out=0, busy=0.
  - Accept occurs on a clock edge with in_valid & in_ready. On that edge: load enc, register ser_out=enc[DATA_W-1], bit count=DATA_W-1, go to SHIFT.
  - The first bit appears in the cycle after accept (latency 1).
- SHIFT:
  - busy=1. Each edge shifts left and drives the next bit; bits leave MSB-first.
  - done=1 during the cycle the final bit (LSB, or parity bit) is on ser_out.
  - in_ready=0 except in the final-bit cycle when GAP_CYCLES==0. A handshake there reloads and continues in SHIFT with no idle bit (back-to-back frames).
  - After the final bit: go to GAP if GAP_CYCLES>0, else to IDLE if no handshake.
- GAP:
  - busy=1, ser_out=0, in_ready=0.
  - Lasts exactly GAP_CYCLES cycles, then IDLE.
- in_data is sampled only at the accept edge. Changes at any other time have no effect.
- Reset mid-frame aborts immediately: ser_out drops to 0 asynchronously, and no done pulse is issued.
- in_valid held high in IDLE produces continuous frames. With GAP_CYCLES==0, ser_out is an unbroken stream.

Optional Feature:
- Macro: SERIAL_NEG_TX_PARITY_EN.
- Defined: one even-parity bit (XOR of enc) is appended after the LSB, so a frame is DATA_W+1 bits. done and the back-to-back in_ready window move to the parity-bit cycle.
- Undefined: no parity bit, frame is DATA_W bits, and no parity logic is synthesized.

Decomposition:
- Shared package serial_link_pkg holds:
  - DATA_W default constant;
  - state enum typedef {IDLE, SHIFT, GAP};
  - function neg_encode(word) returning (~word+1) truncated;
  - function even_parity(word).
- The receiver reuses neg_encode as its decoder.
- No sub-module. The shift register, bit counter and gap counter are small enough to live inline.

Test Plan:
- Reset then accept in_data=3'd1 → ser_out 1,1,1 on cycles 1–3 after accept (enc=7); done high on cycle 3; busy falls after.
- Accept 3'd3 then 3'd6 back-to-back, GAP_CYCLES=0 → ser_out 1,0,1,0,1,0 with no gap; in_ready high only on each final-bit cycle.
- GAP_CYCLES=2, accept 3'd4 → ser_out 1,0,0, then 0,0 gap with busy=1 and in_ready=0; in_ready rises the following cycle.
- Assert rst during the 2nd bit of symbol 3'd2 (enc=6) → ser_out=0 immediately; state IDLE; no done pulse; next accept of 3'd5 yields 0,1,1.
- Loopback into the team's shift-register receiver: sweep all 8 symbols → receiver output equals the original in_data after each frame.
- With SERIAL_NEG_TX_PARITY_EN, accept 3'd1 → ser_out 1,1,1,1 (parity of 111=1); done on the 4th bit. Accept 3'd2 → 1,1,0,0.
